// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO. Issues FIFO reads, absorbs the one-cycle read
// latency in a head/skid buffer and presents the words as a valid/ready stream with a
// frame marker every BURST_LEN words.
module fifo_stream_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic [15:0]      word_count
);

    localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [15:0]      beat_q, beat_d;
    logic [15:0]      count_q, count_d;
    logic             pop;
    logic             rd_ok;
    logic [1:0]       committed;
    logic [1:0]       occ_after;

    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = head_q;
    assign m_last     = m_valid && (beat_q == LAST_BEAT);
    assign word_count = count_q;
    assign pop        = m_valid && m_ready;

    // Read issue: only request a word if a slot is guaranteed free when it lands.
    always_comb begin
        committed  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_ok      = enable && !fifo_empty && (committed < 2'd2);
        // rd_ok alone feeds the inflight flop; that flop is held in reset anyway.
        fifo_rd_en = rd_ok && rst;
    end

    // Buffer, frame beat and word counter next-state.
    always_comb begin
        occ_after  = occ_q - {1'b0, pop};
        head_d     = head_q;
        skid_d     = skid_q;
        beat_d     = beat_q;
        count_d    = count_q;
        inflight_d = rd_ok;

        if (pop && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end
        // Arriving word lands behind whatever is still buffered after the pop.
        if (inflight_q) begin
            if (occ_after == 2'd0) begin
                head_d = fifo_rd_data;
            end else begin
                skid_d = fifo_rd_data;
            end
        end
        occ_d = occ_after + {1'b0, inflight_q};

        if (pop) begin
            beat_d  = (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
            count_d = count_q + 16'd1;
        end
    end

    // State registers; reset discards buffered and inflight words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            beat_q     <= 16'd0;
            count_q    <= 16'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            beat_q     <= beat_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds two instances (BURST_LEN 4
// and 1); a stream scoreboard checks order, frame markers, read issue and counts.
module tb_fifo_stream_reader;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       m_ready;

    logic       rd_en_a, m_valid_a, m_last_a;
    logic [7:0] m_data_a;
    logic [15:0] wc_a;
    logic       rd_en_b, m_valid_b, m_last_b;
    logic [7:0] m_data_b;
    logic [15:0] wc_b;

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en_a), .m_valid(m_valid_a),
        .m_data(m_data_a), .m_last(m_last_a), .m_ready(m_ready), .word_count(wc_a)
    );

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en_b), .m_valid(m_valid_b),
        .m_data(m_data_b), .m_last(m_last_b), .m_ready(m_ready), .word_count(wc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         n;
        logic [7:0] base;
        int         split;
        int         ready_mode;
        int         en_mode;
        bit         gapless;
        int         exp_count;
        int         exp_lasts;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int  reads, pops, lasts, cyc, first_pop_c, last_pop_c;
    bit  last_rd, hold_prev, prev_last;
    logic [7:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        fifo_q.delete();
        exp_q.delete();
        reads = 0; pops = 0; lasts = 0;
        last_rd = 0; hold_prev = 0;
        first_pop_c = -1; last_pop_c = -1;
        fifo_empty = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: check at the falling edge, then update the FIFO model just after the rise.
    task automatic step();
        bit pop, exp_rd, exp_valid, rd_now;
        int pending;
        logic [7:0] w;
        @(negedge clk);
        pop       = m_valid_a && m_ready;
        pending   = reads - pops;
        exp_rd    = rst && enable && !fifo_empty && ((pending - int'(pop)) < 2);
        exp_valid = (reads - int'(last_rd) - pops) > 0;
        chk("rd_en_a", 32'(rd_en_a), 32'(exp_rd));
        chk("rd_en_b", 32'(rd_en_b), 32'(exp_rd));
        chk("occ_bound", 32'(pending <= 2), 32'(1));
        chk("valid_a", 32'(m_valid_a), 32'(exp_valid));
        chk("valid_b", 32'(m_valid_b), 32'(exp_valid));
        chk("count_a", 32'(wc_a), 32'(pops & 16'hffff));
        chk("count_b", 32'(wc_b), 32'(pops & 16'hffff));
        if (hold_prev) begin
            chk("stable_data", 32'(m_data_a), 32'(prev_data));
            chk("stable_last", 32'(m_last_a), 32'(prev_last));
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", 32'(1), 32'(0));
                w = 8'h00;
            end else begin
                w = exp_q.pop_front();
            end
            chk("data_a", 32'(m_data_a), 32'(w));
            chk("data_b", 32'(m_data_b), 32'(w));
            chk("last_a", 32'(m_last_a), 32'((pops % 4) == 3));
            chk("last_b", 32'(m_last_b), 32'(1));
            if (m_last_a) lasts++;
            if (first_pop_c < 0) first_pop_c = cyc;
            last_pop_c = cyc;
            pops++;
        end
        hold_prev = m_valid_a && !m_ready;
        prev_data = m_data_a;
        prev_last = m_last_a;
        rd_now    = rd_en_a;
        @(posedge clk);
        #1;
        if (rd_now) begin
            if (fifo_q.size() == 0) begin
                chk("read_empty", 32'(1), 32'(0));
                fifo_rd_data = 8'h00;
            end else begin
                fifo_rd_data = fifo_q.pop_front();
            end
            reads++;
        end
        fifo_empty = (fifo_q.size() == 0);
        last_rd = rd_now;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        reset_model();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int gap_start;
        int c;
        do_reset();
        gap_start = -1;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < v.split; i++)
            push_word((v.en_mode == 2) ? 8'($urandom) : v.base + 8'(i));
        c = 0;
        while (pops < v.n && c < 300) begin
            if (c == 10)
                for (int i = v.split; i < v.n; i++) push_word(v.base + 8'(i));
            case (v.ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = (c >= 10);
                2: m_ready = (c % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            case (v.en_mode)
                1: begin
                    if (gap_start < 0 && pops >= 2) gap_start = c;
                    enable = !(gap_start >= 0 && c < gap_start + 5);
                end
                2: enable = ($urandom_range(0, 3) != 0);
                default: enable = 1'b1;
            endcase
            if (v.ready_mode == 1 && c == 10) begin
                chk("bp_reads", 32'(reads), 32'(2));
                chk("bp_hold", 32'(m_data_a), 32'(v.base));
            end
            step();
            c++;
        end
        chk("drain", 32'(pops), 32'(v.n));
        chk("final_count", 32'(wc_a), 32'(v.exp_count));
        chk("final_lasts", 32'(lasts), 32'(v.exp_lasts));
        chk("final_reads", 32'(reads), 32'(v.n));
        chk("final_leftover", 32'(exp_q.size()), 32'(0));
        if (v.gapless) chk("gapless", 32'(last_pop_c - first_pop_c), 32'(v.n - 1));
    endtask

    initial begin
        vec_t vecs[6];
        int   budget;
        vecs[0] = '{8,  8'h10, 8,  0, 0, 1'b1, 8,  2};
        vecs[1] = '{6,  8'hA0, 6,  1, 0, 1'b1, 6,  1};
        vecs[2] = '{16, 8'h00, 16, 2, 0, 1'b0, 16, 4};
        vecs[3] = '{6,  8'h30, 6,  0, 1, 1'b0, 6,  1};
        vecs[4] = '{5,  8'h60, 3,  0, 0, 1'b0, 5,  1};
        vecs[5] = '{24, 8'h00, 24, 3, 2, 1'b0, 24, 6};

        cyc = 0;
        fifo_rd_data = 8'h00;
        m_ready = 1'b1;
        enable  = 1'b1;
        rst     = 1'b0;
        reset_model();
        push_word(8'h77);
        #2;
        chk("rst_valid", 32'(m_valid_a), 32'(0));
        chk("rst_data", 32'(m_data_a), 32'(0));
        chk("rst_last_a", 32'(m_last_a), 32'(0));
        chk("rst_last_b", 32'(m_last_b), 32'(0));
        chk("rst_count", 32'(wc_a), 32'(0));
        chk("rst_rd_en", 32'(rd_en_a), 32'(0));

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Asynchronous reset with two words buffered.
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_pending", 32'(reads - pops), 32'(2));
        chk("pre_rst_valid", 32'(m_valid_a), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(m_valid_a), 32'(0));
        chk("async_count", 32'(wc_a), 32'(0));
        chk("async_rd_en", 32'(rd_en_a), 32'(0));
        reset_model();
        step();
        rst = 1'b1;
        m_ready = 1'b1;
        push_word(8'h55);
        budget = 0;
        while (pops < 1 && budget < 20) begin
            if (m_valid_a) begin
                chk("post_rst_data", 32'(m_data_a), 32'(8'h55));
                chk("post_rst_last", 32'(m_last_a), 32'(0));
            end
            step();
            budget++;
        end
        chk("post_rst_pops", 32'(pops), 32'(1));
        chk("post_rst_count", 32'(wc_a), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
